// File: rtl/regularization_cfg_ctrl.sv
// Run-time configuration controller for the 4-channel regularization datapath.
// Optional feature macro: REG_CFG_SAFE_OFF_EN (quiet also requires all switches off).
module regularization_cfg_ctrl #(
    parameter logic [15:0] DEF_DEBOUNCE = 16'd10,
    parameter logic [15:0] DEF_DELAY    = 16'd50,
    parameter logic [15:0] MIN_DEBOUNCE = 16'd1,
    parameter logic [15:0] QUIET_CYCLES = 16'd8,
    parameter logic [15:0] FLUSH_CYCLES = 16'd4,
    parameter logic [15:0] TIMEOUT      = 16'd1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    input  logic [15:0] i_cfg_debounce,
    input  logic [15:0] i_cfg_delay,
    input  logic [3:0]  i_signal,
    output logic [15:0] o_debounce_limit,
    output logic [15:0] o_delay,
    output logic        o_reg_reset,
    output logic        o_busy,
    output logic        o_cfg_done,
    output logic        o_cfg_err
);

    localparam int unsigned CW = 16;
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT_QUIET,
        ST_FLUSH
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_stable_cnt,  w_stable_nxt;
    logic [CW-1:0] r_timeout_cnt, w_timeout_nxt;
    logic [CW-1:0] r_flush_cnt,   w_flush_nxt;
    logic [CW-1:0] r_shadow_deb,  w_shadow_deb_nxt;
    logic [CW-1:0] r_shadow_dly,  w_shadow_dly_nxt;
    logic [CW-1:0] w_deb_nxt;
    logic [CW-1:0] w_dly_nxt;
    logic [SW-1:0] r_sample,      w_sample_nxt;
    logic          w_quiet_sample;
    logic          w_done_nxt;
    logic          w_err_nxt;
    logic          w_reg_reset_nxt;
    logic          w_ready_nxt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == {CW{1'b1}}) ? x : x + CW'(1);
    endfunction

    // One quiet sample: unchanged since last cycle (and all-off when safe mode is built in)
`ifdef REG_CFG_SAFE_OFF_EN
    assign w_quiet_sample = (i_signal == r_sample) && (i_signal == SW'(0));
`else
    assign w_quiet_sample = (i_signal == r_sample);
`endif

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_stable_nxt     = r_stable_cnt;
        w_timeout_nxt    = r_timeout_cnt;
        w_flush_nxt      = r_flush_cnt;
        w_shadow_deb_nxt = r_shadow_deb;
        w_shadow_dly_nxt = r_shadow_dly;
        w_sample_nxt     = r_sample;
        w_deb_nxt        = o_debounce_limit;
        w_dly_nxt        = o_delay;
        w_done_nxt       = 1'b0;
        w_err_nxt        = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_flush_nxt = sat_inc(r_flush_cnt);
                if (r_flush_cnt >= FLUSH_CYCLES - CW'(1)) begin
                    w_flush_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_cfg_valid && o_cfg_ready) begin
                    if ((i_cfg_debounce < MIN_DEBOUNCE) || (i_cfg_delay < i_cfg_debounce)) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_shadow_deb_nxt = i_cfg_debounce;
                        w_shadow_dly_nxt = i_cfg_delay;
                        w_sample_nxt     = i_signal;
                        w_stable_nxt     = '0;
                        w_timeout_nxt    = '0;
                        w_state_nxt      = ST_WAIT_QUIET;
                    end
                end
            end
            ST_WAIT_QUIET: begin
                w_sample_nxt  = i_signal;
                w_stable_nxt  = w_quiet_sample ? sat_inc(r_stable_cnt) : '0;
                w_timeout_nxt = sat_inc(r_timeout_cnt);
                // Quiet wins over a coincident timeout
                if (w_stable_nxt >= QUIET_CYCLES) begin
                    w_deb_nxt   = r_shadow_deb;
                    w_dly_nxt   = r_shadow_dly;
                    w_flush_nxt = '0;
                    w_state_nxt = ST_FLUSH;
                end else if (w_timeout_nxt >= TIMEOUT) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                w_flush_nxt = sat_inc(r_flush_cnt);
                if (r_flush_cnt >= FLUSH_CYCLES - CW'(1)) begin
                    w_flush_nxt = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase

        w_reg_reset_nxt = (w_state_nxt == ST_INIT) || (w_state_nxt == ST_FLUSH);
        w_ready_nxt     = (w_state_nxt == ST_IDLE);
    end

    // State, counters and output registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= ST_INIT;
            r_stable_cnt     <= '0;
            r_timeout_cnt    <= '0;
            r_flush_cnt      <= '0;
            r_shadow_deb     <= '0;
            r_shadow_dly     <= '0;
            r_sample         <= '0;
            o_debounce_limit <= DEF_DEBOUNCE;
            o_delay          <= DEF_DELAY;
            o_reg_reset      <= 1'b1;
            o_busy           <= 1'b1;
            o_cfg_ready      <= 1'b0;
            o_cfg_done       <= 1'b0;
            o_cfg_err        <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_stable_cnt     <= w_stable_nxt;
            r_timeout_cnt    <= w_timeout_nxt;
            r_flush_cnt      <= w_flush_nxt;
            r_shadow_deb     <= w_shadow_deb_nxt;
            r_shadow_dly     <= w_shadow_dly_nxt;
            r_sample         <= w_sample_nxt;
            o_debounce_limit <= w_deb_nxt;
            o_delay          <= w_dly_nxt;
            o_reg_reset      <= w_reg_reset_nxt;
            o_busy           <= ~w_ready_nxt;
            o_cfg_ready      <= w_ready_nxt;
            o_cfg_done       <= w_done_nxt;
            o_cfg_err        <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_regularization_cfg_ctrl.sv
// Self-checking bench for regularization_cfg_ctrl: history-window reference model
// compared every cycle, plus hand-computed timing and value expectations.
module tb_regularization_cfg_ctrl;

    localparam int Q     = 8;
    localparam int FL    = 4;
    localparam int TO    = 1000;
    localparam int DEF_D = 10;
    localparam int DEF_Y = 50;
    localparam int MIN_D = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] deb = '0;
    logic [15:0] dly = '0;
    logic [3:0]  sig = '0;
    logic        o_cfg_ready, o_reg_reset, o_busy, o_cfg_done, o_cfg_err;
    logic [15:0] o_debounce_limit, o_delay;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    regularization_cfg_ctrl dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_cfg_valid      (valid),
        .o_cfg_ready      (o_cfg_ready),
        .i_cfg_debounce   (deb),
        .i_cfg_delay      (dly),
        .i_signal         (sig),
        .o_debounce_limit (o_debounce_limit),
        .o_delay          (o_delay),
        .o_reg_reset      (o_reg_reset),
        .o_busy           (o_busy),
        .o_cfg_done       (o_cfg_done),
        .o_cfg_err        (o_cfg_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: reset-hold countdown, and a window of recent i_signal samples
    int        m_hold;
    bit        m_applying, m_waiting;
    int        m_wait_n;
    logic [3:0] hist[$];
    int        p_deb, p_dly;
    int        e_rr, e_rdy, e_busy, e_done, e_err, e_deb, e_dly;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_hold = FL; m_applying = 0; m_waiting = 0; m_wait_n = 0; hist.delete();
            e_rr = 1; e_rdy = 0; e_busy = 1; e_done = 0; e_err = 0;
            e_deb = DEF_D; e_dly = DEF_Y;
        end else begin
            bit quiet;
            e_done = 0; e_err = 0;
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) begin
                    e_rr = 0; e_done = int'(m_applying); m_applying = 0;
                end
            end else if (m_waiting) begin
                hist.push_back(sig);
                if (hist.size() > Q + 1) hist.delete(0);
                m_wait_n++;
                quiet = (hist.size() == Q + 1);
                foreach (hist[k]) begin
                    if (hist[k] != hist[0]) quiet = 0;
`ifdef REG_CFG_SAFE_OFF_EN
                    if (hist[k] != 4'b0000) quiet = 0;
`endif
                end
                if (quiet) begin
                    e_deb = p_deb; e_dly = p_dly; e_rr = 1;
                    m_hold = FL; m_applying = 1; m_waiting = 0;
                end else if (m_wait_n >= TO) begin
                    e_err = 1; m_waiting = 0;
                end
            end else if (valid) begin
                if (int'(deb) < MIN_D || dly < deb) e_err = 1;
                else begin
                    p_deb = int'(deb); p_dly = int'(dly);
                    m_waiting = 1; m_wait_n = 0; hist.delete(); hist.push_back(sig);
                end
            end
            e_rdy  = (m_hold == 0 && !m_waiting) ? 1 : 0;
            e_busy = 1 - e_rdy;
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            chk("reg_reset", int'(o_reg_reset), e_rr);
            chk("ready", int'(o_cfg_ready), e_rdy);
            chk("busy", int'(o_busy), e_busy);
            chk("done", int'(o_cfg_done), e_done);
            chk("err", int'(o_cfg_err), e_err);
            chk("debounce", int'(o_debounce_limit), e_deb);
            chk("delay", int'(o_delay), e_dly);
        end
    end

    function automatic bit cond(input int sel);
        case (sel)
            0:       return o_reg_reset;
            1:       return o_cfg_err;
            2:       return o_cfg_done;
            default: return !o_reg_reset;
        endcase
    endfunction

    task automatic wait_on(input int sel, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cond(sel)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_%0d: timed out after %0d cycles, required event", sel, budget);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1
    task automatic request(input int d, input int y, output int t);
        int n = 0;
        while (!o_cfg_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", int'(o_cfg_ready), 1);
        valid = 1'b1; deb = 16'(d); dly = 16'(y); t = cyc;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t, at, last, n;
        int exp_deb_now;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #2 rst = 1'b0;

        // 1: init flush; the release cycle counts as the first held cycle
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_reg_reset) n++;
            else break;
        end
        chk("init_hold_cycles", n, 4);
        chk("init_ready", int'(o_cfg_ready), 1);
        chk("init_deb", int'(o_debounce_limit), 10);
        chk("init_dly", int'(o_delay), 50);

        // 2: constant nonzero signal
        sig = 4'b0101;
        request(20, 100, t);
`ifdef REG_CFG_SAFE_OFF_EN
        wait_on(1, 1200, at);
        chk("t2_timeout_at", at - t, 1001);
        chk("t2_deb_kept", int'(o_debounce_limit), 10);
        exp_deb_now = 10;
`else
        wait_on(0, 50, at);
        chk("t2_rise_at", at - t, 9);
        chk("t2_deb", int'(o_debounce_limit), 20);
        chk("t2_dly", int'(o_delay), 100);
        wait_on(2, 50, at);
        chk("t2_done_at", at - t, 13);
        exp_deb_now = 20;
`endif

        // 3: rejected requests
        request(0, 100, t);
        chk("t3a_err", int'(o_cfg_err), 1);
        chk("t3a_rr", int'(o_reg_reset), 0);
        chk("t3a_deb", int'(o_debounce_limit), exp_deb_now);
        request(8, 5, t);
        chk("t3b_err", int'(o_cfg_err), 1);
        chk("t3b_ready", int'(o_cfg_ready), 1);

        // 4: signal toggling every 5 cycles never settles
        sig = 4'b0011;
        request(25, 250, t);
        at = -1;
        for (int i = 1; i <= 1200; i++) begin
            @(negedge clk);
            if (o_cfg_err) begin
                at = cyc;
                break;
            end
            if (i % 5 == 0) sig = ~sig;
        end
        chk("t4_timeout_at", at - t, 1001);
        chk("t4_deb_kept", int'(o_debounce_limit), exp_deb_now);

        // 5: toggling stops, flush follows 9 cycles after the last change
        sig = 4'b0000;
        request(30, 300, t);
        last = cyc;
        for (int i = 0; i < 30; i++) begin
            sig = sig ^ 4'b1000;
            last = cyc;
            @(negedge clk);
        end
        wait_on(0, 50, at);
        chk("t5_rise_after_last", at - last, 9);
        wait_on(2, 20, at);
        chk("t5_deb", int'(o_debounce_limit), 30);
        chk("t5_dly", int'(o_delay), 300);

        // 6: reset during flush
        request(40, 400, t);
        wait_on(0, 50, at);
        chk("t6_deb_applied", int'(o_debounce_limit), 40);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_deb", int'(o_debounce_limit), 10);
        chk("t6_rst_dly", int'(o_delay), 50);
        chk("t6_rst_rr", int'(o_reg_reset), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_cfg_done || o_cfg_err) n++;
        end
        chk("t6_no_pulse", n, 0);
        chk("t6_rr_low", int'(o_reg_reset), 0);
        chk("t6_ready", int'(o_cfg_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
